e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
Multiply/divide unit in the E stage of the five-stage pipeline. It owns the architectural HI/LO registers and executes mult/multu/div/divu with fixed multi-cycle latency. It also executes mthi/mtlo. The HI/LO values it produces are read by mfhi/mflo in E and carried down the pipe to the writeback select. It exports start/busy so hazard control can stall D-stage MDU instructions.

Parameters:
MULT_CYCLES, 5, cycles from start edge until HI/LO hold a mult/multu result
DIV_CYCLES, 10, cycles from start edge until HI/LO hold a div/divu result
CNT_W, 4, width of the latency down-counter; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  1  exception/interrupt flush; the E-stage instruction must not take effect
E_MDUOp  in  3  operation select: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
E_RS  in  32  forwarded rs operand (dividend, multiplicand, or mthi/mtlo source)
E_RT  in  32  forwarded rt operand (divisor or multiplier)
E_Start  out  1  combinational: E_MDUOp is 1..4, req=0 and E_Busy=0
E_Busy  out  1  registered: a mult/div is in flight
E_HI  out  32  current HI register
E_LO  out  32  current LO register

Behaviour:
- Clock and reset: single clock, clk rising edge. reset is synchronous and active-high. On reset, HI=0, LO=0, E_Busy=0, counter=0 and temp results=0. Reset overrides every other input in the same cycle and aborts any in-flight operation.
- Start edge: an edge with E_Start=1 does the following.
  - Latches the full result into temp_hi/temp_lo.
  - mult: signed 64-bit product of E_RS and E_RT; HI=upper 32 bits, LO=lower 32 bits.
  - multu: same, unsigned.
  - div: LO=signed quotient, truncated toward zero; HI=signed remainder, with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Sets E_Busy=1 and loads the counter with MULT_CYCLES or DIV_CYCLES.
- While busy: the counter decrements each edge. On the edge where the counter goes 1->0, temp is copied into HI/LO and E_Busy is cleared.
  - The new HI/LO values are visible exactly N cycles after the start edge, where N is the latency parameter.
  - E_Busy is high for N cycles.
- Divide by zero (div/divu with E_RT=0): timing is unchanged (busy for DIV_CYCLES). At completion HI/LO keep their previous values; no exception is raised.
- Signed overflow case (div with 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- mthi/mtlo: single-cycle. The next edge writes E_RS to HI or LO. They do not assert busy.
  - Ignored when req=1.
  - Ignored while E_Busy=1, because hazard control guarantees a stall then. The in-flight result wins.
- Any op arriving while E_Busy=1 is ignored. No queueing.
- req=1 on a start cycle: no start, no state change.
- req=1 while busy: the in-flight operation still completes. The instruction already left E, so it is committed.
- E_HI/E_LO always show the architectural registers. They never show temp, so mfhi during busy is prevented by stall logic, not by this block.
- Stall rule used outside this block: stall a D-stage MDU instruction (mult/div/mf/mt) when E_Start|E_Busy.

Decomposition:
- The MDU op codes (0..6) and the MULT_CYCLES/DIV_CYCLES defaults belong in the shared constants header. The D-stage decoder uses the same codes.
- No sub-module is needed. The signed/unsigned arithmetic is a few lines of 64-bit combinational logic feeding temp registers, and the counter/busy FSM (states IDLE and BUSY, encoded by counter≠0) lives in this module.

Test Plan:
- mult with E_RS=0xFFFFFFFF, E_RT=2: E_Start high 1 cycle, E_Busy high 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFE. HI/LO are unchanged during cycles 1-4.
- multu with the same operands: HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div with -7 (0xFFFFFFF9) / 2: after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 gives LO=3, HI=1.
- divu 5/0 with prior HI=0x11, LO=0x22: busy for 10 cycles, then HI=0x11, LO=0x22.
- mult with req=1 on its E cycle: E_Start=0, E_Busy stays 0, HI/LO unchanged. mthi 0xABCD with req=1 leaves HI unchanged. mthi 0xABCD with req=0 gives HI=0xABCD the next cycle.
- Start div, assert reset at busy cycle 4: the next cycle shows HI=LO=0 and E_Busy=0, and no late write occurs in later cycles. Separately, req asserted mid-mult: the result still lands at cycle 5.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared MDU constants: operation codes (also used by the D-stage decoder),
// default latencies and the MDU sequencing state type.
package e_mdu_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // True for the multi-cycle operations (mult/multu/div/divu).
  function automatic logic is_start_op(logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit. Owns architectural HI/LO, runs mult/div with
// a fixed latency through a down-counter, and executes mthi/mtlo in one cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no operation in flight; starts and mthi/mtlo are accepted
// ST_BUSY | result parked in temp, counter running; all new ops ignored
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  E_MDUOp,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  output logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      temp_hi_q, temp_lo_q;
  logic             wr_q;
  logic [31:0]      hi_q, lo_q;

  logic [31:0] res_hi_d, res_lo_d;
  logic        is_div;
  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor, rs_mag, rt_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign is_div  = (E_MDUOp == MDU_DIV) || (E_MDUOp == MDU_DIVU);
  assign E_Start = is_start_op(E_MDUOp) && !req && (state_q == ST_IDLE);
  assign E_Busy  = (state_q == ST_BUSY);
  assign E_HI    = hi_q;
  assign E_LO    = lo_q;

  // Result datapath. Signed divide is done on magnitudes so that
  // 0x80000000 / -1 falls out naturally (quotient wraps to 0x80000000).
  // A zero divisor is replaced by 1 only to keep the arithmetic defined;
  // that result is never written to HI/LO.
  always_comb begin
    prod_s   = {{32{E_RS[31]}}, E_RS} * {{32{E_RT[31]}}, E_RT};
    prod_u   = {32'd0, E_RS} * {32'd0, E_RT};
    divisor  = (E_RT == 32'd0) ? 32'd1 : E_RT;
    rs_mag   = E_RS[31] ? -E_RS : E_RS;
    rt_mag   = divisor[31] ? -divisor : divisor;
    q_mag    = rs_mag / rt_mag;
    r_mag    = rs_mag % rt_mag;
    q_s      = (E_RS[31] ^ divisor[31]) ? -q_mag : q_mag;
    r_s      = E_RS[31] ? -r_mag : r_mag;
    q_u      = E_RS / divisor;
    r_u      = E_RS % divisor;
    res_hi_d = 32'd0;
    res_lo_d = 32'd0;
    case (E_MDUOp)
      MDU_MULT:  begin res_hi_d = prod_s[63:32]; res_lo_d = prod_s[31:0]; end
      MDU_MULTU: begin res_hi_d = prod_u[63:32]; res_lo_d = prod_u[31:0]; end
      MDU_DIV:   begin res_hi_d = r_s;           res_lo_d = q_s;          end
      MDU_DIVU:  begin res_hi_d = r_u;           res_lo_d = q_u;          end
      default:   begin res_hi_d = 32'd0;         res_lo_d = 32'd0;        end
    endcase
  end

  // Sequencing FSM: start latches temp and loads the latency counter; the
  // 1->0 counter step commits temp to HI/LO unless the op was a divide by zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      temp_hi_q <= 32'd0;
      temp_lo_q <= 32'd0;
      wr_q      <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (E_Start) begin
            temp_hi_q <= res_hi_d;
            temp_lo_q <= res_lo_d;
            cnt_q     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            wr_q      <= !(is_div && (E_RT == 32'd0));
            state_q   <= ST_BUSY;
          end else if (!req) begin
            if (E_MDUOp == MDU_MTHI) hi_q <= E_RS;
            else if (E_MDUOp == MDU_MTLO) lo_q <= E_RS;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_IDLE;
            if (wr_q) begin
              hi_q <= temp_hi_q;
              lo_q <= temp_lo_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed table, hand-written multi-cycle
// sequences, and random ops against an arithmetic reference model.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [2:0]  E_MDUOp;
  logic [31:0] E_RS, E_RT;
  logic        E_Start, E_Busy;
  logic [31:0] E_HI, E_LO;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] m_hi, m_lo;

  e_mdu dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .E_MDUOp (E_MDUOp),
    .E_RS    (E_RS),
    .E_RT    (E_RT),
    .E_Start (E_Start),
    .E_Busy  (E_Busy),
    .E_HI    (E_HI),
    .E_LO    (E_LO)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: architectural effect of one accepted op.
  function automatic void model_op(logic [2:0] op, logic [31:0] rs, logic [31:0] rt);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    case (op)
      3'd1: begin sp = sa * sb; m_hi = 32'(sp >>> 32); m_lo = 32'(sp); end
      3'd2: begin up = ua * ub; m_hi = 32'(up >> 32);  m_lo = 32'(up); end
      3'd3: if (rt != 32'd0) begin
              sq = sa / sb; sr = sa % sb;
              m_hi = 32'(sr); m_lo = 32'(sq);
            end
      3'd4: if (rt != 32'd0) begin
              m_hi = rs % rt; m_lo = rs / rt;
            end
      3'd5: m_hi = rs;
      3'd6: m_lo = rs;
      default: ;
    endcase
  endfunction

  // Issue one op for one cycle and follow it to completion, checking the
  // start strobe, busy duration and that HI/LO hold steady while busy.
  task automatic exec(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic rq);
    logic exp_start;
    int   n_exp, cnt;
    logic held;
    exp_start = (op >= 3'd1 && op <= 3'd4) && !rq;
    n_exp     = (op == 3'd1 || op == 3'd2) ? 5 : 10;
    @(negedge clk);
    E_MDUOp = op; E_RS = rs; E_RT = rt; req = rq;
    #1 check("start", 64'(E_Start), 64'(exp_start));
    @(negedge clk);
    E_MDUOp = 3'd0; req = 1'b0;
    if (exp_start) begin
      cnt  = 0;
      held = 1'b1;
      while (E_Busy && cnt < 40) begin
        cnt++;
        if (E_HI !== m_hi || E_LO !== m_lo) held = 1'b0;
        @(negedge clk);
      end
      check("busy_cycles", 64'(cnt), 64'(n_exp));
      check("hilo_held_while_busy", 64'(held), 64'd1);
    end else begin
      check("no_busy", 64'(E_Busy), 64'd0);
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs, rt, hi, lo;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int          cnt;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        rq;

    tbl[0] = '{"mult_neg1x2",   3'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[1] = '{"multu_maxx2",   3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    tbl[2] = '{"div_m7_2",      3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{"divu_7_2",      3'd4, 32'd7,        32'd2,        32'd1,        32'd3};
    tbl[4] = '{"mthi_11",       3'd5, 32'h11,       32'd0,        32'h11,       32'd3};
    tbl[5] = '{"mtlo_22",       3'd6, 32'h22,       32'd0,        32'h11,       32'h22};
    tbl[6] = '{"divu_by_zero",  3'd4, 32'd5,        32'd0,        32'h11,       32'h22};
    tbl[7] = '{"div_overflow",  3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    tbl[8] = '{"div_100_m7",    3'd3, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2};

    reset = 1'b1; req = 1'b0; E_MDUOp = 3'd0; E_RS = 32'd0; E_RT = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_hi", 64'(E_HI), 64'd0);
    check("reset_lo", 64'(E_LO), 64'd0);
    check("reset_busy", 64'(E_Busy), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    for (int i = 0; i < 9; i++) begin
      exec(tbl[i].op, tbl[i].rs, tbl[i].rt, 1'b0);
      check({tbl[i].name, "_hi"}, 64'(E_HI), 64'(tbl[i].hi));
      check({tbl[i].name, "_lo"}, 64'(E_LO), 64'(tbl[i].lo));
      m_hi = tbl[i].hi; m_lo = tbl[i].lo;
    end

    // req on the E cycle suppresses starts and moves
    exec(3'd1, 32'd3, 32'd4, 1'b1);
    check("req_mult_hi", 64'(E_HI), 64'd2);
    check("req_mult_lo", 64'(E_LO), 64'hFFFFFFF2);
    exec(3'd5, 32'hABCD, 32'd0, 1'b1);
    check("req_mthi_hi", 64'(E_HI), 64'd2);
    exec(3'd5, 32'hABCD, 32'd0, 1'b0);
    check("mthi_hi", 64'(E_HI), 64'hABCD);
    m_hi = 32'hABCD;

    // req raised mid-mult: the committed op still lands on time
    @(negedge clk);
    E_MDUOp = 3'd1; E_RS = 32'd3; E_RT = 32'd4;
    @(negedge clk);
    E_MDUOp = 3'd0;
    cnt = 0;
    while (E_Busy && cnt < 40) begin
      cnt++;
      if (cnt >= 2) req = 1'b1;
      @(negedge clk);
    end
    req = 1'b0;
    check("req_mid_mult_busy", 64'(cnt), 64'd5);
    check("req_mid_mult_hi", 64'(E_HI), 64'd0);
    check("req_mid_mult_lo", 64'(E_LO), 64'd12);

    // ops issued while busy are ignored; the in-flight result wins
    @(negedge clk);
    E_MDUOp = 3'd4; E_RS = 32'd100; E_RT = 32'd7;
    @(negedge clk);
    E_MDUOp = 3'd0;
    cnt = 0;
    while (E_Busy && cnt < 40) begin
      cnt++;
      if (cnt == 2) begin
        E_MDUOp = 3'd5; E_RS = 32'hDEAD;
      end else if (cnt == 3) begin
        E_MDUOp = 3'd1; E_RS = 32'd9; E_RT = 32'd9;
        #1 check("start_while_busy", 64'(E_Start), 64'd0);
      end else begin
        E_MDUOp = 3'd0;
      end
      @(negedge clk);
    end
    E_MDUOp = 3'd0;
    check("busy_ignore_cycles", 64'(cnt), 64'd10);
    check("busy_ignore_hi", 64'(E_HI), 64'd2);
    check("busy_ignore_lo", 64'(E_LO), 64'd14);

    // reset during a divide aborts it with no late write
    @(negedge clk);
    E_MDUOp = 3'd3; E_RS = 32'hFFFFFFF9; E_RT = 32'd2;
    @(negedge clk);
    E_MDUOp = 3'd0;
    repeat (3) @(negedge clk);
    check("busy_before_reset", 64'(E_Busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hi", 64'(E_HI), 64'd0);
    check("abort_lo", 64'(E_LO), 64'd0);
    check("abort_busy", 64'(E_Busy), 64'd0);
    repeat (12) @(negedge clk);
    check("no_late_write_hi", 64'(E_HI), 64'd0);
    check("no_late_write_lo", 64'(E_LO), 64'd0);
    check("no_late_busy", 64'(E_Busy), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    // random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      rs = $urandom;
      rt = $urandom;
      case ($urandom_range(0, 5))
        0: rt = 32'd0;
        1: rt = 32'($urandom_range(1, 9));
        2: begin rs = 32'h80000000; rt = 32'hFFFFFFFF; end
        default: ;
      endcase
      rq = ($urandom_range(0, 7) == 0);
      exec(op, rs, rt, rq);
      if (!rq) model_op(op, rs, rt);
      check($sformatf("rand%0d_op%0d_hi", i, op), 64'(E_HI), 64'(m_hi));
      check($sformatf("rand%0d_op%0d_lo", i, op), 64'(E_LO), 64'(m_lo));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
